// File: rtl/param_histogram_pkg.sv
// rtl/param_histogram_pkg.sv - shared state encoding and default widths for the histogram block
package param_histogram_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 20;
    localparam int PCT_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_WAIT,
        ST_ACCUM,
        ST_CUM
    } histState_e;

endpackage

// File: rtl/param_histogram_if.sv
// rtl/param_histogram_if.sv - pixel stream, threshold and readout signals of the histogram block
interface param_histogram_if
    import param_histogram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int PCT_W  = PCT_W_DEF
);
    logic [DATA_W-1:0] iData;
    logic              iDataValid;
    logic              iFvalid;
    logic [PCT_W-1:0]  iPctTarget;
    logic [DATA_W-1:0] iReadAddr;
    logic [CNT_W-1:0]  oHisto;
    logic [CNT_W-1:0]  oCumHisto;
    logic [DATA_W-1:0] oThresh;
    logic              oDone;
    logic              oBusy;
    logic              oDrop;

    modport master (
        output iData, iDataValid, iFvalid, iPctTarget, iReadAddr,
        input  oHisto, oCumHisto, oThresh, oDone, oBusy, oDrop
    );

    modport slave (
        input  iData, iDataValid, iFvalid, iPctTarget, iReadAddr,
        output oHisto, oCumHisto, oThresh, oDone, oBusy, oDrop
    );
endinterface

// File: rtl/param_histogram_hist_dpram.sv
// rtl/param_histogram_hist_dpram.sv - single-clock true dual-port RAM with registered read-first outputs
module hist_dpram #(
    parameter int AW = 8,
    parameter int DW = 20
) (
    input  logic          iClk,
    input  logic          weA,
    input  logic [AW-1:0] addrA,
    input  logic [DW-1:0] dinA,
    output logic [DW-1:0] doutA,
    input  logic          weB,
    input  logic [AW-1:0] addrB,
    input  logic [DW-1:0] dinB,
    output logic [DW-1:0] doutB
);
    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Reads return the pre-write contents; the pixel forwarding depends on this.
    always_ff @(posedge iClk) begin
        if (weA) mem[addrA] <= dinA;
        if (weB) mem[addrB] <= dinB;
        doutA <= mem[addrA];
        doutB <= mem[addrB];
    end
endmodule

// File: rtl/param_histogram.sv
// rtl/param_histogram.sv - frame histogram with cumulative publish and percentile threshold
module param_histogram
    import param_histogram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int PCT_W  = PCT_W_DEF
) (
    input logic              iClk,
    input logic              iRst,
    param_histogram_if.slave bus
);
    localparam int NBINS = 1 << DATA_W;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [DATA_W+1:0] CUM_END = (DATA_W+2)'(NBINS + 2);

    histState_e state;
    logic fvPrev, fvRise, fvFall, draining, accept, sweepRd;
    logic [DATA_W-1:0] clrAddr, threshCand, readAddrQ, pubAddr;
    logic [DATA_W+1:0] cumCnt;
    logic [CNT_W-1:0] total, target, runSum, pubSum, fwdBase, incCnt;
    logic [CNT_W:0] sumWide;
    logic [CNT_W+PCT_W-1:0] targetProd;
    logic threshFound, pubWe;
    logic s1Valid, s2Valid, s3Valid;
    logic [DATA_W-1:0] s1Addr, s2Addr, s3Addr;
    logic [CNT_W-1:0] s2Cnt, s3Cnt;
    logic accWeA, accWeB;
    logic [DATA_W-1:0] accAddrA, accAddrB;
    logic [CNT_W-1:0] accDinB, accDoutA;
    logic [CNT_W-1:0] unusedAccDoutB, unusedHistDoutA, unusedCumDoutA;

    assign fvRise  = bus.iFvalid & ~fvPrev;
    assign fvFall  = ~bus.iFvalid & fvPrev;
    assign accept  = (state == ST_ACCUM) && !draining && bus.iFvalid && bus.iDataValid;
    assign sweepRd = (state == ST_CUM) && (cumCnt[DATA_W+1:DATA_W] == 2'b00);
    assign targetProd = {{PCT_W{1'b0}}, total} * {{CNT_W{1'b0}}, bus.iPctTarget};

    // Stage-2 and stage-3 counts stand in for RAM data not yet visible to the read port.
    always_comb begin
        fwdBase = accDoutA;
        if (s2Valid && s2Addr == s1Addr)      fwdBase = s2Cnt;
        else if (s3Valid && s3Addr == s1Addr) fwdBase = s3Cnt;
        incCnt  = (fwdBase == CNT_MAX) ? fwdBase : fwdBase + 1'b1;
        sumWide = {1'b0, runSum} + {1'b0, accDoutA};
        pubSum  = sumWide[CNT_W] ? CNT_MAX : sumWide[CNT_W-1:0];
    end

    always_comb begin
        accWeA   = 1'b0;
        accAddrA = bus.iData;
        if (state == ST_CLEAR) begin
            accWeA   = 1'b1;
            accAddrA = clrAddr;
        end else if (state == ST_CUM) begin
            accAddrA = cumCnt[DATA_W-1:0];
        end
        accWeB   = s2Valid | sweepRd;
        accAddrB = s2Valid ? s2Addr : cumCnt[DATA_W-1:0];
        accDinB  = s2Valid ? s2Cnt : '0;
    end

    always_ff @(posedge iClk) begin
        fvPrev    <= bus.iFvalid;
        readAddrQ <= bus.iReadAddr;
        s1Valid   <= accept;
        s1Addr    <= bus.iData;
        s2Valid   <= s1Valid;
        s2Addr    <= s1Addr;
        s2Cnt     <= incCnt;
        s3Valid   <= s2Valid;
        s3Addr    <= s2Addr;
        s3Cnt     <= s2Cnt;
        pubWe     <= sweepRd;
        pubAddr   <= cumCnt[DATA_W-1:0];
        bus.oDone <= 1'b0;
        bus.oDrop <= fvRise && (state != ST_WAIT);
        if (iRst) begin
            state       <= ST_CLEAR;
            clrAddr     <= '0;
            draining    <= 1'b0;
            total       <= '0;
            target      <= '0;
            s1Valid     <= 1'b0;
            s2Valid     <= 1'b0;
            s3Valid     <= 1'b0;
            pubWe       <= 1'b0;
            bus.oThresh <= '0;
            bus.oDone   <= 1'b0;
            bus.oDrop   <= 1'b0;
            bus.oBusy   <= 1'b1;
        end else begin
            unique case (state)
                ST_CLEAR: begin
                    clrAddr <= clrAddr + 1'b1;
                    if (&clrAddr) begin
                        state     <= ST_WAIT;
                        bus.oBusy <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (fvRise) begin
                        state    <= ST_ACCUM;
                        total    <= '0;
                        draining <= 1'b0;
                    end
                end
                ST_ACCUM: begin
                    if (accept && total != CNT_MAX) total <= total + 1'b1;
                    // One extra cycle lets the last pixel's write land before the sweep reads it.
                    if (draining) begin
                        state       <= ST_CUM;
                        bus.oBusy   <= 1'b1;
                        cumCnt      <= '0;
                        runSum      <= '0;
                        threshFound <= 1'b0;
                        threshCand  <= '1;
                    end else if (fvFall) begin
                        draining <= 1'b1;
                        target   <= targetProd[CNT_W+PCT_W-1:PCT_W];
                    end
                end
                ST_CUM: begin
                    cumCnt <= cumCnt + 1'b1;
                    if (pubWe) begin
                        runSum <= pubSum;
                        if (!threshFound && pubSum >= target) begin
                            threshFound <= 1'b1;
                            threshCand  <= pubAddr;
                        end
                    end
                    if (cumCnt == CUM_END) begin
                        state       <= ST_WAIT;
                        bus.oBusy   <= 1'b0;
                        bus.oDone   <= 1'b1;
                        bus.oThresh <= threshCand;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    hist_dpram #(.AW(DATA_W), .DW(CNT_W)) uAccum (
        .iClk(iClk),
        .weA(accWeA), .addrA(accAddrA), .dinA('0), .doutA(accDoutA),
        .weB(accWeB), .addrB(accAddrB), .dinB(accDinB), .doutB(unusedAccDoutB)
    );

    hist_dpram #(.AW(DATA_W), .DW(CNT_W)) uPubHist (
        .iClk(iClk),
        .weA(pubWe), .addrA(pubAddr), .dinA(accDoutA), .doutA(unusedHistDoutA),
        .weB(1'b0), .addrB(readAddrQ), .dinB('0), .doutB(bus.oHisto)
    );

    hist_dpram #(.AW(DATA_W), .DW(CNT_W)) uPubCum (
        .iClk(iClk),
        .weA(pubWe), .addrA(pubAddr), .dinA(pubSum), .doutA(unusedCumDoutA),
        .weB(1'b0), .addrB(readAddrQ), .dinB('0), .doutB(bus.oCumHisto)
    );
endmodule

// File: tb/tb_param_histogram.sv
// tb/tb_param_histogram.sv - directed table-driven bench for param_histogram
module tb_param_histogram;

    typedef struct {
        int frame;
        int addr;
        int expH;
        int expC;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic fv = 1'b0;
    logic dv = 1'b0;
    logic [7:0] data = '0;
    logic [7:0] pct = '0;
    logic [7:0] rdAddr = '0;
    int errors = 0;
    int checks = 0;
    int pixQ[$];
    vec_t vecs[$];
    logic busyO, doneO, dropO;
    int histO, cumO, threshO;

    always #5 clk = ~clk;

    param_histogram_if #(.DATA_W(8), .CNT_W(20), .PCT_W(8)) bus ();
    param_histogram_if #(.DATA_W(3), .CNT_W(4), .PCT_W(8)) busS ();

    assign bus.iData       = data;
    assign bus.iDataValid  = dv;
    assign bus.iFvalid     = fv & ~sel;
    assign bus.iPctTarget  = pct;
    assign bus.iReadAddr   = rdAddr;
    assign busS.iData      = data[2:0];
    assign busS.iDataValid = dv;
    assign busS.iFvalid    = fv & sel;
    assign busS.iPctTarget = pct;
    assign busS.iReadAddr  = rdAddr[2:0];

    param_histogram #(.DATA_W(8), .CNT_W(20), .PCT_W(8)) dut (
        .iClk(clk),
        .iRst(rst),
        .bus(bus)
    );

    param_histogram #(.DATA_W(3), .CNT_W(4), .PCT_W(8)) dutSat (
        .iClk(clk),
        .iRst(rst),
        .bus(busS)
    );

    always_comb begin
        busyO   = sel ? busS.oBusy : bus.oBusy;
        doneO   = sel ? busS.oDone : bus.oDone;
        dropO   = sel ? busS.oDrop : bus.oDrop;
        histO   = sel ? int'(busS.oHisto) : int'(bus.oHisto);
        cumO    = sel ? int'(busS.oCumHisto) : int'(bus.oCumHisto);
        threshO = sel ? int'(busS.oThresh) : int'(bus.oThresh);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit cond(input int which);
        case (which)
            0:       return busyO;
            1:       return !busyO;
            default: return doneO;
        endcase
    endfunction

    task automatic waitFor(input int which, input int budget, input string name, output int n);
        n = 0;
        while (!cond(which) && n < budget) begin
            tick();
            n++;
        end
        if (!cond(which)) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: waited %0d cycles, required event within %0d", name, n, budget);
        end
    endtask

    task automatic sendPixels();
        fv = 1'b1;
        tick();
        tick();
        foreach (pixQ[i]) begin
            data = 8'(pixQ[i]);
            dv   = 1'b1;
            tick();
        end
        dv = 1'b0;
        fv = 1'b0;
        tick();
    endtask

    task automatic runFrame(input string tag, input int expLat, input int expThr);
        int n;
        sendPixels();
        waitFor(0, 20, {tag, " busy"}, n);
        waitFor(2, 600, {tag, " done"}, n);
        check({tag, " done latency"}, n, expLat);
        check({tag, " thresh"}, threshO, expThr);
    endtask

    task automatic readBin(input int a, output int h, output int c);
        rdAddr = 8'(a);
        tick();
        tick();
        h = histO;
        c = cumO;
    endtask

    task automatic checkTable(input int frame);
        int h, c;
        foreach (vecs[i]) begin
            if (vecs[i].frame == frame) begin
                readBin(vecs[i].addr, h, c);
                check($sformatf("f%0d hist[%0d]", frame, vecs[i].addr), h, vecs[i].expH);
                check($sformatf("f%0d cum[%0d]", frame, vecs[i].addr), c, vecs[i].expC);
            end
        end
    endtask

    initial begin
        int n;
        vecs.push_back('{1, 0, 0, 0});
        vecs.push_back('{1, 6, 0, 0});
        vecs.push_back('{1, 7, 1000, 1000});
        vecs.push_back('{1, 8, 0, 1000});
        vecs.push_back('{1, 255, 0, 1000});
        vecs.push_back('{2, 4, 0, 0});
        vecs.push_back('{2, 5, 4, 4});
        vecs.push_back('{2, 6, 1, 5});
        vecs.push_back('{2, 7, 0, 5});
        vecs.push_back('{2, 255, 0, 5});
        vecs.push_back('{3, 0, 4, 4});
        vecs.push_back('{3, 63, 4, 256});
        vecs.push_back('{3, 64, 4, 260});
        vecs.push_back('{3, 255, 4, 1024});
        vecs.push_back('{4, 10, 3, 3});
        vecs.push_back('{4, 20, 0, 3});
        vecs.push_back('{5, 10, 0, 0});
        vecs.push_back('{5, 20, 2, 2});
        vecs.push_back('{5, 255, 0, 2});
        vecs.push_back('{6, 9, 2, 2});
        vecs.push_back('{6, 199, 0, 2});
        vecs.push_back('{6, 200, 1, 3});
        vecs.push_back('{7, 2, 0, 0});
        vecs.push_back('{7, 3, 15, 15});
        vecs.push_back('{7, 7, 0, 15});

        // reset state and initial clear sweep
        rst = 1'b1;
        tick(); tick(); tick();
        check("reset busy", int'(busyO), 1);
        check("reset done", int'(doneO), 0);
        check("reset drop", int'(dropO), 0);
        check("reset thresh", threshO, 0);
        rst = 1'b0;
        waitFor(1, 400, "initial clear", n);
        check("initial clear cycles", n, 256);

        // 1000 pixels of value 7, half-way percentile
        pixQ.delete();
        repeat (1000) pixQ.push_back(7);
        pct = 8'd128;
        runFrame("f1", 259, 7);
        checkTable(1);

        // back-to-back same-bin pixels exercise both forwarding distances
        pixQ = '{5, 5, 5, 6, 5};
        pct = 8'd0;
        runFrame("f2", 259, 0);
        checkTable(2);

        // ramp, four pixels per bin, quarter percentile
        pixQ.delete();
        for (int i = 0; i < 256; i++) repeat (4) pixQ.push_back(i);
        pct = 8'd64;
        runFrame("f3", 259, 63);
        checkTable(3);

        // frame start during CUM is dropped
        pixQ = '{10, 10, 10};
        pct = 8'd128;
        sendPixels();
        waitFor(0, 20, "f4 busy", n);
        repeat (5) tick();
        fv = 1'b1;
        tick();
        check("f4 drop pulse", int'(dropO), 1);
        tick();
        check("f4 drop cleared", int'(dropO), 0);
        repeat (5) begin
            data = 8'd20;
            dv   = 1'b1;
            tick();
        end
        dv = 1'b0;
        waitFor(2, 600, "f4 done", n);
        check("f4 thresh", threshO, 10);
        tick(); tick();
        fv = 1'b0;
        tick(); tick(); tick();
        checkTable(4);

        pixQ = '{20, 20};
        pct = 8'd128;
        runFrame("f5", 259, 20);
        checkTable(5);

        // reset in the middle of the CUM sweep
        pixQ = '{200, 200, 200, 200, 200, 200};
        pct = 8'd128;
        sendPixels();
        waitFor(0, 20, "f6 busy", n);
        repeat (100) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("f6 reset busy", int'(busyO), 1);
        check("f6 reset thresh", threshO, 0);
        check("f6 reset done", int'(doneO), 0);
        waitFor(1, 400, "f6 clear", n);
        check("f6 clear cycles", n, 256);
        pixQ = '{9, 9, 200};
        runFrame("f6", 259, 9);
        checkTable(6);

        // narrow-count instance: bin and total saturation
        sel = 1'b1;
        tick();
        pixQ.delete();
        repeat (20) pixQ.push_back(3);
        pct = 8'd128;
        runFrame("f7", 11, 3);
        checkTable(7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
